bch_ecc_dual_bit_checker: RTL and testbench



---
 rtl/bch_ecc_pkg.sv | 48 ++++
 rtl/bch_ecc_dual_bit_checker_step.sv | 12 +
 rtl/bch_ecc_dual_bit_checker.sv | 149 ++++++++++++++
 tb/tb_bch_ecc_dual_bit_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_ecc_pkg.sv
// Shared constants and BCH(64,56) helpers for the HDMI data island subpacket ECC.
// bchEccStep carries the generator polynomial used by the encoder.
package bch_ecc_pkg;

  localparam int SUBPACKET_DATA_BITS = 56;
  localparam int PARITY_BITS         = 8;
  localparam int SUBPACKET_CLOCKS    = 32;
  localparam int DATA_CLOCKS         = 28;
  localparam int CODE_BITS           = SUBPACKET_DATA_BITS + PARITY_BITS;

  localparam logic [PARITY_BITS-1:0] BCH_FEEDBACK = 8'b1000_0011;

  typedef logic [CODE_BITS-1:0][PARITY_BITS-1:0] syn_table_t;

  typedef struct packed {
    logic [PARITY_BITS-1:0]         syn;
    logic [PARITY_BITS-1:0]         ecc_rx;
    logic [SUBPACKET_DATA_BITS-1:0] data;
  } stage1_t;

  function automatic logic [PARITY_BITS-1:0] bchEccStep(input logic [PARITY_BITS-1:0] ecc,
                                                         input logic bit_in);
    return (ecc >> 1) ^ ((ecc[0] ^ bit_in) ? BCH_FEEDBACK : 8'h00);
  endfunction

  // Syndrome seen when only code bit 'index' is in error (data 0..55, parity 56..63).
  function automatic logic [PARITY_BITS-1:0] syndromeForBit(input int index);
    logic [PARITY_BITS-1:0] ecc;
    ecc = 8'h00;
    if (index >= SUBPACKET_DATA_BITS) begin
      ecc = 8'h01 << (index - SUBPACKET_DATA_BITS);
    end else begin
      for (int j = 0; j < SUBPACKET_DATA_BITS; j++) begin
        ecc = bchEccStep(ecc, (j == index));
      end
    end
    return ecc;
  endfunction

  function automatic syn_table_t buildSyndromeTable();
    syn_table_t t;
    for (int i = 0; i < CODE_BITS; i++) begin
      t[i] = syndromeForBit(i);
    end
    return t;
  endfunction

endpackage

// File: rtl/bch_ecc_dual_bit_checker_step.sv
// Single BCH bit-step: advances the running ECC by one transmitted bit.
module bch_ecc_dual_bit_checker_step
  import bch_ecc_pkg::*;
(
  input  logic [PARITY_BITS-1:0] i_ecc,
  input  logic                   i_bit,
  output logic [PARITY_BITS-1:0] o_ecc
);

  assign o_ecc = bchEccStep(i_ecc, i_bit);

endmodule

// File: rtl/bch_ecc_dual_bit_checker.sv
// Receive-side BCH(64,56) checker: collects a subpacket at 2 bits/clock, forms the
// syndrome, and corrects single-bit errors in a two-stage pipeline behind the collector.
module bch_ecc_dual_bit_checker
  import bch_ecc_pkg::*;
#(
  parameter int ENABLE_CORRECTION = 1
) (
  input  logic                           clock,
  input  logic                           resetN,
  input  logic [1:0]                     data,
  input  logic                           isFirstDataClock,
  output logic [SUBPACKET_DATA_BITS-1:0] subpacketData,
  output logic [PARITY_BITS-1:0]         eccReceived,
  output logic [PARITY_BITS-1:0]         syndrome,
  output logic [5:0]                     errorPosition,
  output logic                           valid,
  output logic                           errorDetected,
  output logic                           errorCorrected,
  output logic                           uncorrectable,
  output logic                           busy
);

  localparam syn_table_t SYN_TABLE = buildSyndromeTable();

  logic                           r_busy;
  logic [4:0]                     r_count;
  logic [PARITY_BITS-1:0]         r_ecc;
  logic [PARITY_BITS-1:0]         r_ecc_rx;
  logic [SUBPACKET_DATA_BITS-1:0] r_buf;
  logic                           r_done;
  stage1_t                        r_s1;
  logic                           r_s1_valid;

  logic                           w_active;
  logic [4:0]                     w_sym;
  logic [PARITY_BITS-1:0]         w_ecc_seed;
  logic [PARITY_BITS-1:0]         w_ecc_mid;
  logic [PARITY_BITS-1:0]         w_ecc_next;
  logic                           w_match;
  logic [5:0]                     w_match_pos;
  logic                           w_correct;
  logic                           w_nonzero;
  logic [SUBPACKET_DATA_BITS-1:0] w_data_fixed;

  // isFirstDataClock forces symbol 0 and a zero ECC seed, even mid-packet.
  assign w_active   = isFirstDataClock | r_busy;
  assign w_sym      = isFirstDataClock ? 5'd0 : r_count;
  assign w_ecc_seed = isFirstDataClock ? 8'h00 : r_ecc;
  assign busy       = r_busy;

  bch_ecc_dual_bit_checker_step u_step0 (
    .i_ecc (w_ecc_seed),
    .i_bit (data[0]),
    .o_ecc (w_ecc_mid)
  );

  bch_ecc_dual_bit_checker_step u_step1 (
    .i_ecc (w_ecc_mid),
    .i_bit (data[1]),
    .o_ecc (w_ecc_next)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_busy   <= 1'b0;
      r_count  <= 5'd0;
      r_ecc    <= 8'h00;
      r_ecc_rx <= 8'h00;
      r_buf    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_active) begin
        if (w_sym < 5'(DATA_CLOCKS)) begin
          r_buf[{w_sym, 1'b0} +: 2] <= data;
          r_ecc                     <= w_ecc_next;
        end else begin
          r_ecc_rx[{w_sym[1:0], 1'b0} +: 2] <= data;
        end
        if (w_sym == 5'(SUBPACKET_CLOCKS - 1)) begin
          r_busy  <= 1'b0;
          r_count <= 5'd0;
          r_done  <= 1'b1;
        end else begin
          r_busy  <= 1'b1;
          r_count <= w_sym + 5'd1;
        end
      end
    end
  end

  // Stage 1 snapshots the finished packet so the collector can start the next one.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_done;
      if (r_done) begin
        r_s1.syn    <= r_ecc ^ r_ecc_rx;
        r_s1.ecc_rx <= r_ecc_rx;
        r_s1.data   <= r_buf;
      end
    end
  end

  // Descending scan so the lowest matching index is the one that remains.
  always_comb begin
    w_match      = 1'b0;
    w_match_pos  = 6'd0;
    for (int i = CODE_BITS - 1; i >= 0; i--) begin
      if (r_s1.syn == SYN_TABLE[i]) begin
        w_match     = 1'b1;
        w_match_pos = 6'(i);
      end
    end
    w_nonzero    = (r_s1.syn != 8'h00);
    w_correct    = (ENABLE_CORRECTION != 0) && w_nonzero && w_match;
    w_data_fixed = r_s1.data;
    if (w_correct && (w_match_pos < 6'(SUBPACKET_DATA_BITS))) begin
      w_data_fixed[w_match_pos] = ~w_data_fixed[w_match_pos];
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      valid          <= 1'b0;
      subpacketData  <= '0;
      eccReceived    <= 8'h00;
      syndrome       <= 8'h00;
      errorPosition  <= 6'd0;
      errorDetected  <= 1'b0;
      errorCorrected <= 1'b0;
      uncorrectable  <= 1'b0;
    end else begin
      valid <= r_s1_valid;
      if (r_s1_valid) begin
        subpacketData  <= w_data_fixed;
        eccReceived    <= r_s1.ecc_rx;
        syndrome       <= r_s1.syn;
        errorPosition  <= w_correct ? w_match_pos : 6'd0;
        errorDetected  <= w_nonzero;
        errorCorrected <= w_correct;
        uncorrectable  <= w_nonzero && !w_correct;
      end
    end
  end

endmodule

// File: tb/tb_bch_ecc_dual_bit_checker.sv
// Directed bench for bch_ecc_dual_bit_checker: a correcting and a detect-only
// instance share the input stream; expected decode results come from a golden encoder.
`timescale 1ns/1ps
module tb_bch_ecc_dual_bit_checker;

  typedef struct packed {
    logic [31:0] cyc;
    logic [55:0] data;
    logic [7:0]  ecc_rx;
    logic [7:0]  syn;
    logic [5:0]  pos;
    logic        det;
    logic        corr;
    logic        unc;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  localparam logic [55:0] PKT = 56'h00_1234_5678_9ABC;

  logic        clock;
  logic        resetN;
  logic [1:0]  data;
  logic        isFirstDataClock;
  int          cyc;
  int          n_tests;
  int          n_fail;

  logic [55:0] m_data, n_data;
  logic [7:0]  m_ecc, n_ecc, m_syn, n_syn;
  logic [5:0]  m_pos, n_pos;
  logic        m_valid, n_valid, m_det, n_det, m_corr, n_corr, m_unc, n_unc, m_busy, n_busy;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_nc_q[$];

  bch_ecc_dual_bit_checker #(.ENABLE_CORRECTION(1)) dut (
    .clock(clock), .resetN(resetN), .data(data), .isFirstDataClock(isFirstDataClock),
    .subpacketData(m_data), .eccReceived(m_ecc), .syndrome(m_syn), .errorPosition(m_pos),
    .valid(m_valid), .errorDetected(m_det), .errorCorrected(m_corr),
    .uncorrectable(m_unc), .busy(m_busy)
  );

  bch_ecc_dual_bit_checker #(.ENABLE_CORRECTION(0)) dut_nc (
    .clock(clock), .resetN(resetN), .data(data), .isFirstDataClock(isFirstDataClock),
    .subpacketData(n_data), .eccReceived(n_ecc), .syndrome(n_syn), .errorPosition(n_pos),
    .valid(n_valid), .errorDetected(n_det), .errorCorrected(n_corr),
    .uncorrectable(n_unc), .busy(n_busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // golden encoder: HDMI subpacket BCH, LSbit first, zero seed
  function automatic logic [7:0] gold_ecc(input logic [55:0] d);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    for (int i = 0; i < 56; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[7:1]} ^ (fb ? 8'h83 : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [63:0] encode(input logic [55:0] d);
    return {gold_ecc(d), d};
  endfunction

  function automatic logic [7:0] gold_single_syn(input int i);
    logic [55:0] v;
    logic [7:0]  p;
    v = '0;
    p = 8'h00;
    if (i < 56) begin
      v[i] = 1'b1;
      return gold_ecc(v);
    end
    p[i-56] = 1'b1;
    return p;
  endfunction

  function automatic exp_t make_exp(input logic [63:0] rx, input bit en, input int k);
    exp_t        e;
    logic [63:0] fixed;
    e        = '0;
    fixed    = rx;
    e.cyc    = 32'(k + 33);
    e.ecc_rx = rx[63:56];
    e.syn    = gold_ecc(rx[55:0]) ^ rx[63:56];
    e.det    = (e.syn != 8'h00);
    if (en && e.det) begin
      for (int i = 0; i < 64; i++) begin
        if (!e.corr && gold_single_syn(i) == e.syn) begin
          e.corr = 1'b1;
          e.pos  = 6'(i);
        end
      end
    end
    if (e.corr) fixed[e.pos] = ~fixed[e.pos];
    e.unc  = e.det && !e.corr;
    e.data = fixed[55:0];
    return e;
  endfunction

  // driver tasks
  task automatic send_packet(input logic [63:0] code, input int n_syms, input bit expect_valid);
    int k;
    for (int s = 0; s < n_syms; s++) begin
      @(negedge clock);
      if (s == 0) k = cyc + 1;
      isFirstDataClock = (s == 0);
      data             = code[2*s +: 2];
    end
    if (expect_valid) begin
      exp_q.push_back(make_exp(code, 1'b1, k));
      exp_nc_q.push_back(make_exp(code, 1'b0, k));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      isFirstDataClock = 1'b0;
      data             = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic check_zero_outputs(input string who);
    check({who, "_data"}, m_data, 0);
    check({who, "_ecc"}, m_ecc, 0);
    check({who, "_syn"}, m_syn, 0);
    check({who, "_pos"}, m_pos, 0);
    check({who, "_valid"}, m_valid, 0);
    check({who, "_det"}, m_det, 0);
    check({who, "_corr"}, m_corr, 0);
    check({who, "_unc"}, m_unc, 0);
    check({who, "_busy"}, m_busy, 0);
    check({who, "_nc_valid"}, n_valid, 0);
    check({who, "_nc_data"}, n_data, 0);
  endtask

  task automatic check_out(input string who, input exp_t e, input logic [55:0] d,
                           input logic [7:0] ecc, input logic [7:0] syn, input logic [5:0] pos,
                           input logic det, input logic corr, input logic unc);
    check({who, "_valid_cycle"}, cyc, e.cyc);
    check({who, "_data"}, d, e.data);
    check({who, "_ecc_rx"}, ecc, e.ecc_rx);
    check({who, "_syndrome"}, syn, e.syn);
    check({who, "_err_pos"}, pos, e.pos);
    check({who, "_err_det"}, det, e.det);
    check({who, "_err_corr"}, corr, e.corr);
    check({who, "_uncorr"}, unc, e.unc);
  endtask

  // scoreboard: one expected record per valid pulse
  always @(negedge clock) begin
    exp_t e;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check("main_spurious_valid", m_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_out("main", e, m_data, m_ecc, m_syn, m_pos, m_det, m_corr, m_unc);
      end
    end
    if (n_valid) begin
      if (exp_nc_q.size() == 0) begin
        check("nc_spurious_valid", n_valid, 0);
      end else begin
        e = exp_nc_q.pop_front();
        check_out("nc", e, n_data, n_ecc, n_syn, n_pos, n_det, n_corr, n_unc);
      end
    end
  end

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    resetN           = 1'b1;
    data             = 2'b00;
    isFirstDataClock = 1'b0;
    #3 resetN = 1'b0;
    repeat (2) @(negedge clock);
    #1 check_zero_outputs("reset");
    @(negedge clock);
    resetN = 1'b1;

    // all-zero packet, first data clock sampled at edge 10 -> valid at 43
    while (cyc < 8) @(negedge clock);
    send_packet(64'h0, 32, 1'b1);
    idle(40);

    // three clean packets back to back
    for (int i = 0; i < 3; i++) send_packet(encode(PKT), 32, 1'b1);
    idle(40);

    // single data error, single parity error, double data error
    send_packet(encode(PKT) ^ (64'd1 << 17), 32, 1'b1);
    send_packet(encode(PKT) ^ (64'd1 << 60), 32, 1'b1);
    send_packet(encode(PKT) ^ (64'd1 << 3) ^ (64'd1 << 40), 32, 1'b1);
    idle(40);

    // restart at symbol 15: first packet dropped, second decoded
    send_packet({$urandom(), $urandom()}, 15, 1'b0);
    send_packet(encode(PKT) ^ (64'd1 << 5), 32, 1'b1);
    idle(40);

    // reset at symbol 30: nothing emitted, next packet decodes
    send_packet(encode(PKT), 30, 1'b0);
    check("busy_mid_packet", m_busy, 1);
    @(negedge clock);
    resetN           = 1'b0;
    isFirstDataClock = 1'b0;
    #1 check_zero_outputs("midreset");
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    idle(40);
    check("busy_after_reset", m_busy, 0);
    send_packet(encode(56'h00_A5A5_0F0F_3C3C), 32, 1'b1);
    idle(3);

    for (int i = 0; i < 100 && (exp_q.size() != 0 || exp_nc_q.size() != 0); i++) begin
      @(negedge clock);
    end
    check("main_pending_valids", exp_q.size(), 0);
    check("nc_pending_valids", exp_nc_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
